ldm_stm_seq: RTL
================

# ldm_stm_seq

Multi-cycle load/store-multiple sequencer for the ARM datapath. On a `start` pulse it walks a 16-bit register list one register per cycle: for LDM it takes data from data memory and drives the register file write port, and for STM it drives the register file read port and writes data memory. It sits beside the register file as a second master of its ports, muxed in by the controller while `busy` is high, and optionally writes back the updated base register.

## Interface
Parameters:
- XLEN, 32, data/address width
Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- ld  in  1  1 = LDM, 0 = STM
- up  in  1  1 = increment, 0 = decrement
- pre  in  1  1 = before, 0 = after (IB/DB vs IA/DA)
- wb  in  1  write back final base to rn
- rn  in  4  base register index
- base  in  XLEN  base register value
- reglist  in  16  register list, bit i = Ri
- rf_ra  out  4  register file read address (STM)
- rf_rd  in  XLEN  register file read data, combinational
- rf_we  out  1  register file write enable
- rf_wa  out  4  register file write address
- rf_wd  out  XLEN  register file write data
- pc_we  out  1  PC load strobe (LDM with R15 in list)
- pc_wd  out  XLEN  PC load value
- mem_addr  out  XLEN  data memory address
- mem_we  out  1  data memory write enable
- mem_wd  out  XLEN  data memory write data
- mem_rd  in  XLEN  data memory read data, combinational
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse on the final active cycle

## Operation
- On `start` in IDLE, latch ld, up, pre, wb, rn, and reglist into a working list. Compute n = popcount(reglist), and compute the start address and the final base in XLEN-bit modular arithmetic:
  - IA: start base; final base+4n
  - IB: start base+4; final base+4n
  - DA: start base-4n+4; final base-4n
  - DB: start base-4n; final base-4n
- States:
  - IDLE -> XFER on start with n>0.
  - XFER: each cycle, select the lowest set bit i of the working list and drive mem_addr = cur_addr. Then clear bit i and set cur_addr += 4. Lowest register always goes to the lowest address.
    - LDM: rf_we=1, rf_wa=i, rf_wd=mem_rd. If i=15, assert pc_we=1 and pc_wd=mem_rd instead, with rf_we=0.
    - STM: rf_ra=i, mem_we=1, mem_wd=rf_rd.
  - XFER -> WB after the last bit when wb is latched; otherwise -> IDLE.
  - WB: rf_we=1, rf_wa=rn, rf_wd=final base. Skipped (-> IDLE, no write) for LDM with rn in the list, because the loaded value wins. WB -> IDLE.
- Empty list (n=0): IDLE -> IDLE. Done pulses the cycle after start, with no memory or register writes and no writeback.
- `start` while busy is ignored.
- Reset mid-operation: return to IDLE immediately and discard the remaining list, so no further writes occur.

## Timing
- Reset values: state IDLE; all outputs 0 (busy, done, rf_we, pc_we, mem_we, addresses, data).
- Cycle 0: start sampled. Cycles 1..n: one transfer per cycle. Cycle n+1: writeback, if enabled.
- busy is high from cycle 1 through the last active cycle.
- done is high exactly on the last active cycle: n, n+1, or 1 for an empty list.
- Strobes (rf_we, pc_we, mem_we) are combinational from state and take effect at the end-of-cycle edge. Memory and register file reads are same-cycle.

## Configuration
- LDM_STM_WB_EN defined: base writeback supported as above.
- LDM_STM_WB_EN undefined: `wb` is ignored, the WB state and final-base adder are not built, and XFER always returns to IDLE.

## Structure
- Package ldm_stm_pkg holds:
  - the state enum (IDLE, XFER, WB)
  - the addressing-mode encoding {up,pre}
  - the constant WORD_BYTES=4
- Sub-module reg_pick: combinational 16-bit lowest-set-bit encoder that outputs the index, a valid flag, and the list with that bit cleared. Popcount lives in the top level.

## Test plan
- STM IA, base=0x100, reglist=0x0013 (R0,R1,R4), wb=1, rn=13 -> mem writes of R0, R1, R4 to 0x100, 0x104, 0x108 in cycles 1-3; R13=0x10C in cycle 4; done in cycle 4.
- LDM DB, base=0x200, reglist=0x8006, wb=0 -> reads 0x1F4, 0x1F8, 0x1FC into R1, R2, and PC (pc_we in cycle 3); done in cycle 3; rf_we=0 in cycle 3.
- LDM IB, rn=2, reglist=0x0006, wb=1 -> R1=mem[base+4], R2=mem[base+8]; no writeback; done in cycle 2.
- reglist=0, start -> done in cycle 1; all write strobes stay 0.
- reset_n=0 in cycle 2 of a 4-register STM -> exactly 1 memory write occurred; outputs 0 and IDLE in the next cycle. A new start after release completes normally.
- start re-asserted during busy; base=0xFFFFFFFC IA with 2 registers -> second start ignored; addresses 0xFFFFFFFC, 0x00000000 (wrap).

Source files
------------

// File: rtl/ldm_stm_pkg.sv
// ldm_stm_pkg: shared types and constants for the load/store-multiple sequencer.
//   state_e  : sequencer states (IDLE, XFER, WB)
//   mode_e   : addressing mode, encoded as {up, pre}
//   WORD_BYTES : address step between consecutive transferred registers
package ldm_stm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_DB = 2'b01,
    MODE_IA = 2'b10,
    MODE_IB = 2'b11
  } mode_e;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/ldm_stm_seq_reg_pick.sv
// reg_pick: combinational lowest-set-bit encoder for a 16-entry register list.
//   list_i  [15:0] : working register list
//   idx_o   [3:0]  : index of the lowest set bit (0 when list is empty)
//   valid_o        : list has at least one bit set
//   rest_o  [15:0] : list with the lowest set bit cleared
module reg_pick
  import ldm_stm_pkg::*;
(
  input  logic [15:0] list_i,
  output logic [3:0]  idx_o,
  output logic        valid_o,
  output logic [15:0] rest_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_i[i]) idx_o = 4'(i);
    end
  end

  assign valid_o = |list_i;
  // x & (x-1) clears exactly the lowest set bit.
  assign rest_o  = list_i & (list_i - 16'd1);

endmodule

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: load/store-multiple sequencer. Walks a 16-bit register list
// one register per cycle, lowest register to lowest address.
//   LDM: data memory -> register file write port (R15 goes to the PC strobe).
//   STM: register file read port -> data memory.
// Optional feature macro: LDM_STM_WB_EN enables final-base writeback to rn.
// Ports:
//   clk, reset_n (sync, active-low)
//   start, ld, up, pre, wb, rn, base, reglist : operation request (IDLE only)
//   rf_ra/rf_rd            : register file read (combinational data)
//   rf_we/rf_wa/rf_wd      : register file write
//   pc_we/pc_wd            : PC load
//   mem_addr/mem_we/mem_wd/mem_rd : data memory (combinational read)
//   busy, done             : status; done pulses on the final active cycle
module ldm_stm_seq
  import ldm_stm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            ld,
  input  logic            up,
  input  logic            pre,
  input  logic            wb,
  input  logic [3:0]      rn,
  input  logic [XLEN-1:0] base,
  input  logic [15:0]     reglist,
  output logic [3:0]      rf_ra,
  input  logic [XLEN-1:0] rf_rd,
  output logic            rf_we,
  output logic [3:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            pc_we,
  output logic [XLEN-1:0] pc_wd,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd,
  output logic            busy,
  output logic            done
);

  localparam logic [XLEN-1:0] WORD = XLEN'(WORD_BYTES);

  state_e          state_q, state_d;
  logic [15:0]     list_q, list_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            ld_q, ld_d;
  logic            empty_q, empty_d;   // empty-list request: done pulses next cycle

  logic [4:0]      cnt;
  logic [XLEN-1:0] span;
  logic [XLEN-1:0] start_addr;
  logic [3:0]      pick_idx;
  logic            pick_valid;
  logic [15:0]     pick_rest;

`ifdef LDM_STM_WB_EN
  logic            wb_go_q, wb_go_d;
  logic [3:0]      rn_q, rn_d;
  logic [XLEN-1:0] final_q, final_d;
  logic [XLEN-1:0] final_base;
`else
  logic            unused_cfg;
  assign unused_cfg = ^{wb, rn};
`endif

  reg_pick u_pick (
    .list_i  (list_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid),
    .rest_o  (pick_rest)
  );

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(reglist[i]);
  end

  assign span = XLEN'(cnt) << 2;

  // Lowest transfer address for each mode; the walk always ascends from here.
  always_comb begin
    case (mode_e'({up, pre}))
      MODE_IA: start_addr = base;
      MODE_IB: start_addr = base + WORD;
      MODE_DA: start_addr = base - span + WORD;
      default: start_addr = base - span;
    endcase
  end

`ifdef LDM_STM_WB_EN
  assign final_base = up ? (base + span) : (base - span);
`endif

  always_comb begin
    state_d  = state_q;
    list_d   = list_q;
    addr_d   = addr_q;
    ld_d     = ld_q;
    empty_d  = 1'b0;
`ifdef LDM_STM_WB_EN
    wb_go_d  = wb_go_q;
    rn_d     = rn_q;
    final_d  = final_q;
`endif
    rf_ra    = '0;
    rf_we    = 1'b0;
    rf_wa    = '0;
    rf_wd    = '0;
    pc_we    = 1'b0;
    pc_wd    = '0;
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        busy = empty_q;
        done = empty_q;
        if (start && !empty_q) begin
          ld_d   = ld;
          list_d = reglist;
          addr_d = start_addr;
`ifdef LDM_STM_WB_EN
          // A loaded base register wins over the writeback.
          wb_go_d = wb & ~(ld & reglist[rn]);
          rn_d    = rn;
          final_d = final_base;
`endif
          if (cnt == '0) empty_d = 1'b1;
          else           state_d = XFER;
        end
      end

      XFER: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        if (ld_q) begin
          if (pick_idx == 4'd15) begin
            pc_we = 1'b1;
            pc_wd = mem_rd;
          end else begin
            rf_we = 1'b1;
            rf_wa = pick_idx;
            rf_wd = mem_rd;
          end
        end else begin
          rf_ra  = pick_idx;
          mem_we = 1'b1;
          mem_wd = rf_rd;
        end
        list_d = pick_rest;
        addr_d = addr_q + WORD;
        if (!pick_valid || pick_rest == '0) begin
`ifdef LDM_STM_WB_EN
          if (wb_go_q) begin
            state_d = WB;
          end else begin
            state_d = IDLE;
            done    = 1'b1;
          end
`else
          state_d = IDLE;
          done    = 1'b1;
`endif
        end
      end

`ifdef LDM_STM_WB_EN
      WB: begin
        busy    = 1'b1;
        done    = 1'b1;
        rf_we   = 1'b1;
        rf_wa   = rn_q;
        rf_wd   = final_q;
        state_d = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase

    // A reset landing mid-operation must not let the current cycle's write commit.
    if (!reset_n) begin
      rf_we  = 1'b0;
      pc_we  = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      empty_q <= 1'b0;
      list_q  <= '0;
    end else begin
      state_q <= state_d;
      empty_q <= empty_d;
      list_q  <= list_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    ld_q   <= ld_d;
`ifdef LDM_STM_WB_EN
    wb_go_q <= wb_go_d;
    rn_q    <= rn_d;
    final_q <= final_d;
`endif
  end

endmodule
